banked_data_mem: RTL and testbench

//   Parametrised multi-bank data memory for the multi-lane datapath: NUM_BANKS independent banks

---
 rtl/banked_data_mem_pkg.sv | 26 ++
 rtl/banked_data_mem_if.sv | 30 +++
 rtl/banked_data_mem_bank.sv | 33 +++
 rtl/banked_data_mem.sv | 101 ++++++++++
 tb/tb_banked_data_mem.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/banked_data_mem_pkg.sv
// Shared types and helpers for the banked data memory: controller state and byte-lane merge.
package dm_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } dm_state_e;

  // Widest supported word; callers zero-extend into and truncate out of this width.
  localparam int unsigned DM_MAX_W = 512;
  localparam int unsigned DM_BE_W  = DM_MAX_W / 8;

  function automatic logic [DM_MAX_W-1:0] byte_merge(
    input logic [DM_MAX_W-1:0] old_w,
    input logic [DM_MAX_W-1:0] new_w,
    input logic [DM_BE_W-1:0]  be
  );
    logic [DM_MAX_W-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < DM_BE_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/banked_data_mem_if.sv
// Request/response port of the banked data memory.
interface banked_data_mem_if #(
  parameter int unsigned BANK_W = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              Req_valid;
  logic              Req_ready;
  logic              Req_write;
  logic              Req_bcast;
  logic [BANK_W-1:0] Req_bank;
  logic [ADDR_W-1:0] Req_addr;
  logic [DATA_W-1:0] Req_wdata;
  logic [DATA_W/8-1:0] Req_be;
  logic              Rsp_valid;
  logic              Rsp_ready;
  logic [DATA_W-1:0] Rsp_data;
  logic              Rsp_err;
  logic              Init_done;

  modport master (
    output Req_valid, Req_write, Req_bcast, Req_bank, Req_addr, Req_wdata, Req_be, Rsp_ready,
    input  Req_ready, Rsp_valid, Rsp_data, Rsp_err, Init_done
  );

  modport slave (
    input  Req_valid, Req_write, Req_bcast, Req_bank, Req_addr, Req_wdata, Req_be, Rsp_ready,
    output Req_ready, Rsp_valid, Rsp_data, Rsp_err, Init_done
  );
endinterface

// File: rtl/banked_data_mem_bank.sv
// One memory bank: byte-enabled write port and registered read port.
module dm_bank
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is never reset so contents survive reset when no clear is requested.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= DATA_W'(byte_merge(DM_MAX_W'(mem[waddr]), DM_MAX_W'(wdata), DM_BE_W'(wbe)));
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/banked_data_mem.sv
// Multi-bank data memory: clear FSM, bank decode, broadcast writes and a one-entry response register.
module banked_data_mem
  import dm_pkg::*;
#(
  parameter int unsigned NUM_BANKS      = 16,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic         Clk,
  input logic         Rst_n,
  banked_data_mem_if.slave bus
);
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned BE_W   = DATA_W / 8;

  dm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clearing;
  logic              init_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [BANK_W-1:0] rsp_bank_q;
  logic              acc, acc_wr, acc_rd, in_range;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   wbe;
  logic [DATA_W-1:0] rd [NUM_BANKS];

  assign in_range      = 32'(bus.Req_bank) < NUM_BANKS;
  assign bus.Req_ready = init_q && (!rsp_valid_q || bus.Rsp_ready);
  assign acc           = bus.Req_valid && bus.Req_ready;
  assign acc_wr        = acc && bus.Req_write;
  assign acc_rd        = acc && !bus.Req_write;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clearing = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clearing = 1'b1;
        if (cnt_q == '1) state_d = ST_READY;
        else             cnt_d   = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= (state_d == ST_READY);
    end
  end

  // Out-of-range reads park the bank index at 0; Rsp_err forces the data to zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_bank_q  <= '0;
    end else if (acc_rd) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= !in_range;
      rsp_bank_q  <= in_range ? bus.Req_bank : '0;
    end else if (bus.Rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.Rsp_valid = rsp_valid_q;
  assign bus.Rsp_err   = rsp_err_q;
  assign bus.Rsp_data  = rsp_err_q ? '0 : rd[rsp_bank_q];
  assign bus.Init_done = init_q;

  assign waddr = clearing ? cnt_q : bus.Req_addr;
  assign wdata = clearing ? '0 : bus.Req_wdata;
  assign wbe   = clearing ? '1 : bus.Req_be;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dm_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .we    (clearing || (acc_wr && (bus.Req_bcast || bus.Req_bank == BANK_W'(b)))),
      .waddr (waddr),
      .wdata (wdata),
      .wbe   (wbe),
      .re    (acc_rd && bus.Req_bank == BANK_W'(b)),
      .raddr (bus.Req_addr),
      .rdata (rd[b])
    );
  end
endmodule

// File: tb/tb_banked_data_mem.sv
// Randomised and directed check of banked_data_mem against an array/queue reference model.
module tb_banked_data_mem;
  localparam int unsigned NB = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned BW = 4;
  localparam int unsigned DEPTH = 256;

  typedef struct {
    logic [DW-1:0] data;
    bit            err;
  } rsp_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int unsigned total = 0;
  int unsigned bad = 0;

  logic [DW-1:0] model [NB][DEPTH];
  rsp_t          pend [$];

  always #5 Clk = ~Clk;

  banked_data_mem_if #(.BANK_W(BW), .ADDR_W(AW), .DATA_W(DW)) bus ();

  banked_data_mem #(
    .NUM_BANKS      (NB),
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.Req_valid = 1'b0; bus.Req_write = 1'b0; bus.Req_bcast = 1'b0;
    bus.Req_bank = '0; bus.Req_addr = '0; bus.Req_wdata = '0; bus.Req_be = '0;
    bus.Rsp_ready = 1'b1;
  endtask

  task automatic model_clear();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) model[b][a] = '0;
    pend.delete();
  endtask

  // Releases reset and checks the port stays closed for exactly DEPTH cycles.
  task automatic release_and_wait();
    @(negedge Clk);
    chk("rst_rsp", {bus.Rsp_valid, bus.Rsp_err, bus.Rsp_data, bus.Init_done, bus.Req_ready}, '0);
    Rst_n = 1'b1;
    model_clear();
    for (int k = 1; k < DEPTH; k++) begin
      @(negedge Clk);
      chk("clearing", {bus.Init_done, bus.Req_ready}, '0);
    end
    @(negedge Clk);
    chk("init_done", bus.Init_done, 1'b1);
  endtask

  // One clock of traffic: drive inputs, check outputs against the model, update the model.
  task automatic cyc(input bit v, input bit w, input bit bc, input logic [BW-1:0] bk,
                     input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                     input logic [DW/8-1:0] be, input bit rr);
    bit exp_rdy;
    rsp_t r;
    @(negedge Clk);
    bus.Req_valid = v; bus.Req_write = w; bus.Req_bcast = bc; bus.Req_bank = bk;
    bus.Req_addr = ad; bus.Req_wdata = wd; bus.Req_be = be; bus.Rsp_ready = rr;
    #1;
    chk("rsp_valid", bus.Rsp_valid, pend.size() != 0);
    if (pend.size() != 0) begin
      chk("rsp_data", bus.Rsp_data, pend[0].data);
      chk("rsp_err", bus.Rsp_err, pend[0].err);
    end
    exp_rdy = (pend.size() == 0) || rr;
    chk("req_ready", bus.Req_ready, exp_rdy);
    if (pend.size() != 0 && rr) void'(pend.pop_front());
    if (v && exp_rdy) begin
      if (w) begin
        for (int b = 0; b < NB; b++) begin
          if (bc || int'(bk) == b)
            for (int i = 0; i < DW / 8; i++)
              if (be[i]) model[b][ad][8*i +: 8] = wd[8*i +: 8];
        end
      end else begin
        r.err  = int'(bk) >= NB;
        r.data = r.err ? '0 : model[bk][ad];
        pend.push_back(r);
      end
    end
  endtask

  task automatic wr(input logic [BW-1:0] bk, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                    input logic [DW/8-1:0] be, input bit bc);
    cyc(1'b1, 1'b1, bc, bk, ad, wd, be, 1'b1);
  endtask

  task automatic rd(input logic [BW-1:0] bk, input logic [AW-1:0] ad);
    cyc(1'b1, 1'b0, 1'b0, bk, ad, '0, '0, 1'b1);
  endtask

  task automatic nop(input bit rr);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, rr);
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(negedge Clk);
    release_and_wait();

    rd(4'd11, 8'hFF); nop(1'b1);
    chk("top_addr_zero", bus.Rsp_data, 32'h0);

    wr(4'd3, 8'h10, 32'h0000_00A5, 4'b0001, 1'b0);
    rd(4'd3, 8'h10); rd(4'd4, 8'h10); nop(1'b1);
    chk("bank4_untouched", bus.Rsp_data, 32'h0);

    wr(4'd5, 8'h33, 32'h1122_3344, 4'b1111, 1'b0);
    wr(4'd5, 8'h33, 32'hAABB_CCDD, 4'b0101, 1'b0);
    rd(4'd5, 8'h33); nop(1'b1);
    chk("byte_merge", bus.Rsp_data, 32'h11BB_33DD);
    wr(4'd5, 8'h33, 32'hFFFF_FFFF, 4'b0000, 1'b0);

    wr(4'd14, 8'h20, 32'h0000_005A, 4'b1111, 1'b1);
    rd(4'd0, 8'h20); rd(4'd7, 8'h20); rd(4'd11, 8'h20); nop(1'b1);
    chk("bcast_b11", bus.Rsp_data, 32'h5A);

    wr(4'd13, 8'h40, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    rd(4'd13, 8'h40); nop(1'b1);
    chk("oor_err", {bus.Rsp_err, bus.Rsp_data}, {1'b1, 32'h0});
    for (int b = 0; b < NB; b++) rd(BW'(b), 8'h40);
    nop(1'b1);

    rd(4'd3, 8'h10);
    cyc(1'b1, 1'b0, 1'b0, 4'd5, 8'h33, '0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd5, 8'h33, '0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd5, 8'h33, '0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd5, 8'h33, '0, '0, 1'b1);
    rd(4'd0, 8'h20); nop(1'b0); nop(1'b1); nop(1'b1);

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
          BW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), $urandom,
          4'($urandom), $urandom_range(0, 9) < 7);
    end
    nop(1'b1); nop(1'b1);

    // Reset with data present and a read pending, then again in the middle of the clear.
    wr(4'd2, 8'h07, 32'hCAFE_F00D, 4'b1111, 1'b0);
    rd(4'd2, 8'h07);
    @(negedge Clk); Rst_n = 1'b0; idle_inputs(); pend.delete();
    repeat (2) @(negedge Clk);
    release_and_wait();
    rd(4'd2, 8'h07); nop(1'b1);
    @(negedge Clk);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (100) @(negedge Clk);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    release_and_wait();
    rd(4'd2, 8'h07); rd(4'd0, 8'h20); rd(4'd5, 8'h33); nop(1'b1); nop(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
